// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-memory loads/stores over req/ack, stalls upstream
// while busy, steers byte lanes, extends loads. Optional misalignment trap: ALIGN_CHECK_EN.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  control_in,
    input  logic [31:0] pc_4_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] sw_in,
    input  logic [4:0]  regdst_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_regdst,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc_4,
    output logic        misalign
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    // Fields of the outstanding access, needed when the ack arrives.
    logic        cap_reg_write_q, cap_reg_write_d;
    logic        cap_mem_to_reg_q, cap_mem_to_reg_d;
    logic [1:0]  cap_size_q, cap_size_d;
    logic        cap_sext_q, cap_sext_d;
    logic [31:0] cap_alu_q, cap_alu_d;
    logic [4:0]  cap_regdst_q, cap_regdst_d;
    logic [31:0] cap_pc_4_q, cap_pc_4_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_regdst_q, wb_regdst_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] wb_pc_4_q, wb_pc_4_d;
    logic        misalign_q, misalign_d;

    logic        is_bubble;
    logic        is_mem;
    logic        is_write;
    logic        in_half;
    logic        in_byte;
    logic        misaligned;
    logic [3:0]  issue_be;
    logic [31:0] issue_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign is_bubble = control_in[0];
    assign is_mem    = !is_bubble && (control_in[7] || control_in[6]);
    assign is_write  = control_in[6];
    assign in_half   = (control_in[3:2] == 2'b01);
    assign in_byte   = (control_in[3:2] == 2'b10);

`ifdef ALIGN_CHECK_EN
    assign misaligned = (!in_half && !in_byte && (alu_in[1:0] != 2'b00)) ||
                        (in_half && alu_in[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Lane steering for the access being issued; surplus low address bits are ignored.
    always_comb begin
        issue_be    = 4'b1111;
        issue_wdata = sw_in;
        if (in_byte) begin
            issue_be    = 4'b0001 << alu_in[1:0];
            issue_wdata = {4{sw_in[7:0]}};
        end else if (in_half) begin
            issue_be    = 4'b0011 << {alu_in[1], 1'b0};
            issue_wdata = {2{sw_in[15:0]}};
        end
    end

    always_comb begin
        case (cap_alu_q[1:0])
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = cap_alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (cap_size_q)
            2'b10:   load_data = cap_sext_q ? {{24{load_byte[7]}}, load_byte}
                                            : {24'h0, load_byte};
            2'b01:   load_data = cap_sext_q ? {{16{load_half[15]}}, load_half}
                                            : {16'h0, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state_q)
                StIdle:  stall = is_mem && !misaligned;
                StBusy:  stall = !dmem_ack;
                default: stall = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        we_d             = we_q;
        addr_d           = addr_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        cap_reg_write_d  = cap_reg_write_q;
        cap_mem_to_reg_d = cap_mem_to_reg_q;
        cap_size_d       = cap_size_q;
        cap_sext_d       = cap_sext_q;
        cap_alu_d        = cap_alu_q;
        cap_regdst_d     = cap_regdst_q;
        cap_pc_4_d       = cap_pc_4_q;
        wb_valid_d       = wb_valid_q;
        wb_reg_write_d   = wb_reg_write_q;
        wb_regdst_d      = wb_regdst_q;
        wb_data_d        = wb_data_q;
        wb_pc_4_d        = wb_pc_4_q;
        misalign_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (is_bubble) begin
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end else if (is_mem && misaligned) begin
                    misalign_d     = 1'b1;
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end else if (is_mem) begin
                    state_d          = StBusy;
                    req_d            = 1'b1;
                    we_d             = is_write;
                    addr_d           = {alu_in[31:2], 2'b00};
                    be_d             = issue_be;
                    wdata_d          = issue_wdata;
                    cap_reg_write_d  = control_in[5];
                    cap_mem_to_reg_d = control_in[4];
                    cap_size_d       = control_in[3:2];
                    cap_sext_d       = control_in[1];
                    cap_alu_d        = alu_in;
                    cap_regdst_d     = regdst_in;
                    cap_pc_4_d       = pc_4_in;
                    // Also drop reg_write so a stalled MEM/WB never sees a stale write.
                    wb_valid_d       = 1'b0;
                    wb_reg_write_d   = 1'b0;
                end else begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = control_in[5];
                    wb_regdst_d    = regdst_in;
                    wb_data_d      = alu_in;
                    wb_pc_4_d      = pc_4_in;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    state_d        = StIdle;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = cap_reg_write_q;
                    wb_regdst_d    = cap_regdst_q;
                    wb_data_d      = cap_mem_to_reg_q ? load_data : cap_alu_q;
                    wb_pc_4_d      = cap_pc_4_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            req_q            <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= 32'h0;
            be_q             <= 4'h0;
            wdata_q          <= 32'h0;
            cap_reg_write_q  <= 1'b0;
            cap_mem_to_reg_q <= 1'b0;
            cap_size_q       <= 2'b00;
            cap_sext_q       <= 1'b0;
            cap_alu_q        <= 32'h0;
            cap_regdst_q     <= 5'h0;
            cap_pc_4_q       <= 32'h0;
            wb_valid_q       <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_regdst_q      <= 5'h0;
            wb_data_q        <= 32'h0;
            wb_pc_4_q        <= 32'h0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            be_q             <= be_d;
            wdata_q          <= wdata_d;
            cap_reg_write_q  <= cap_reg_write_d;
            cap_mem_to_reg_q <= cap_mem_to_reg_d;
            cap_size_q       <= cap_size_d;
            cap_sext_q       <= cap_sext_d;
            cap_alu_q        <= cap_alu_d;
            cap_regdst_q     <= cap_regdst_d;
            cap_pc_4_q       <= cap_pc_4_d;
            wb_valid_q       <= wb_valid_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_regdst_q      <= wb_regdst_d;
            wb_data_q        <= wb_data_d;
            wb_pc_4_q        <= wb_pc_4_d;
            misalign_q       <= misalign_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_regdst    = wb_regdst_q;
    assign wb_data      = wb_data_q;
    assign wb_pc_4      = wb_pc_4_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: reset, ALU/bubble, word/byte/half accesses,
// misaligned word load (both ALIGN_CHECK_EN builds) and reset mid-access.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  control_in;
    logic [31:0] pc_4_in;
    logic [31:0] alu_in;
    logic [31:0] sw_in;
    logic [4:0]  regdst_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_regdst;
    logic [31:0] wb_data;
    logic [31:0] wb_pc_4;
    logic        misalign;

    int n_checks = 0;
    int n_pass   = 0;
    int stall_cycles;

    localparam logic [7:0] MR   = 8'h80;
    localparam logic [7:0] MW   = 8'h40;
    localparam logic [7:0] RW   = 8'h20;
    localparam logic [7:0] M2R  = 8'h10;
    localparam logic [7:0] HALF = 8'h04;
    localparam logic [7:0] BYTE = 8'h08;
    localparam logic [7:0] SEXT = 8'h02;
    localparam logic [7:0] BUB  = 8'h01;

    mem_stage_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .control_in   (control_in),
        .pc_4_in      (pc_4_in),
        .alu_in       (alu_in),
        .sw_in        (sw_in),
        .regdst_in    (regdst_in),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_regdst    (wb_regdst),
        .wb_data      (wb_data),
        .wb_pc_4      (wb_pc_4),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] r, input logic [31:0] p);
        control_in = c;
        alu_in     = a;
        sw_in      = s;
        regdst_in  = r;
        pc_4_in    = p;
    endtask

    initial begin
        // Reset held with a mem op presented.
        reset      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(MR | RW | M2R, 32'h100, 32'h0, 5'd7, 32'h8);
        repeat (2) step();
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_wb_rw", 32'(wb_reg_write), 32'h0);
        check("rst_wb_regdst", 32'(wb_regdst), 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_pc4", wb_pc_4, 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        reset = 1'b1;
        step();

        // ALU op, then bubble (with a stray ack that must be ignored).
        drive(RW, 32'd5, 32'h0, 5'd3, 32'h44);
        #1;
        check("alu_stall", 32'(stall), 32'h0);
        step();
        check("alu_wb_valid", 32'(wb_valid), 32'h1);
        check("alu_wb_data", wb_data, 32'h5);
        check("alu_wb_regdst", 32'(wb_regdst), 32'h3);
        check("alu_wb_rw", 32'(wb_reg_write), 32'h1);
        check("alu_wb_pc4", wb_pc_4, 32'h44);
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        dmem_ack = 1'b1;
        #1;
        check("bub_stall", 32'(stall), 32'h0);
        step();
        dmem_ack = 1'b0;
        check("bub_wb_valid", 32'(wb_valid), 32'h0);
        check("bub_wb_rw", 32'(wb_reg_write), 32'h0);
        check("bub_req", 32'(dmem_req), 32'h0);

        // Word load, ack after three waiting BUSY cycles.
        drive(MR | RW | M2R, 32'h100, 32'h0, 5'd7, 32'h200);
        stall_cycles = 0;
        #1;
        if (stall) stall_cycles++;
        check("lw_issue_stall", 32'(stall), 32'h1);
        step();
        check("lw_req", 32'(dmem_req), 32'h1);
        check("lw_we", 32'(dmem_we), 32'h0);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_be", 32'(dmem_be), 32'hF);
        check("lw_wb_valid_busy", 32'(wb_valid), 32'h0);
        repeat (3) begin
            if (stall) stall_cycles++;
            check("lw_busy_stall", 32'(stall), 32'h1);
            check("lw_busy_req", 32'(dmem_req), 32'h1);
            step();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        if (stall) stall_cycles++;
        check("lw_ack_stall", 32'(stall), 32'h0);
        check("lw_stall_cycles", 32'(stall_cycles), 32'd4);
        step();
        dmem_ack = 1'b0;
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        check("lw_wb_valid", 32'(wb_valid), 32'h1);
        check("lw_wb_data", wb_data, 32'hDEADBEEF);
        check("lw_wb_regdst", 32'(wb_regdst), 32'h7);
        check("lw_wb_pc4", wb_pc_4, 32'h200);
        check("lw_req_drop", 32'(dmem_req), 32'h0);
        step();
        check("lw_wb_valid_pulse", 32'(wb_valid), 32'h0);

        // Byte load sign-extended, then back-to-back zero-extended.
        drive(MR | RW | M2R | BYTE | SEXT, 32'h203, 32'h0, 5'd9, 32'h300);
        #1;
        check("lb_issue_stall", 32'(stall), 32'h1);
        step();
        check("lb_req", 32'(dmem_req), 32'h1);
        check("lb_addr", dmem_addr, 32'h200);
        check("lb_be", 32'(dmem_be), 32'h8);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF0011;
        #1;
        check("lb_ack_stall", 32'(stall), 32'h0);
        step();
        dmem_ack = 1'b0;
        check("lb_wb_valid", 32'(wb_valid), 32'h1);
        check("lb_sext_data", wb_data, 32'hFFFFFF80);
        drive(MR | RW | M2R | BYTE, 32'h203, 32'h0, 5'd9, 32'h304);
        #1;
        check("lbu_b2b_stall", 32'(stall), 32'h1);
        step();
        check("lbu_req", 32'(dmem_req), 32'h1);
        check("lbu_be", 32'(dmem_be), 32'h8);
        check("lbu_wb_valid_busy", 32'(wb_valid), 32'h0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        check("lbu_wb_valid", 32'(wb_valid), 32'h1);
        check("lbu_zext_data", wb_data, 32'h00000080);

        // Half store.
        drive(MW | HALF, 32'h42, 32'h1234ABCD, 5'd0, 32'h400);
        #1;
        check("sh_issue_stall", 32'(stall), 32'h1);
        step();
        check("sh_req", 32'(dmem_req), 32'h1);
        check("sh_we", 32'(dmem_we), 32'h1);
        check("sh_addr", dmem_addr, 32'h40);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hABCDABCD);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        check("sh_wb_valid", 32'(wb_valid), 32'h1);
        check("sh_wb_rw", 32'(wb_reg_write), 32'h0);
        check("sh_wb_data", wb_data, 32'h42);
        check("sh_req_drop", 32'(dmem_req), 32'h0);

        // Misaligned word load.
        drive(MR | RW | M2R, 32'h102, 32'h0, 5'd4, 32'h500);
        dmem_rdata = 32'hCAFEF00D;
`ifdef ALIGN_CHECK_EN
        #1;
        check("mis_stall", 32'(stall), 32'h0);
        step();
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        check("mis_pulse", 32'(misalign), 32'h1);
        check("mis_req", 32'(dmem_req), 32'h0);
        check("mis_wb_valid", 32'(wb_valid), 32'h0);
        check("mis_wb_rw", 32'(wb_reg_write), 32'h0);
        step();
        check("mis_pulse_end", 32'(misalign), 32'h0);
`else
        #1;
        check("mis_stall", 32'(stall), 32'h1);
        step();
        check("mis_req", 32'(dmem_req), 32'h1);
        check("mis_addr", dmem_addr, 32'h100);
        check("mis_be", 32'(dmem_be), 32'hF);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        check("mis_wb_valid", 32'(wb_valid), 32'h1);
        check("mis_wb_data", wb_data, 32'hCAFEF00D);
        check("mis_tied0", 32'(misalign), 32'h0);
`endif

        // Reset asserted mid-access; a late ack must be ignored.
        drive(MR | RW | M2R, 32'h300, 32'h0, 5'd6, 32'h600);
        step();
        check("rb_req", 32'(dmem_req), 32'h1);
        reset = 1'b0;
        #1;
        check("rb_req_drop", 32'(dmem_req), 32'h0);
        check("rb_stall", 32'(stall), 32'h0);
        drive(BUB, 32'h0, 32'h0, 5'd0, 32'h0);
        #1;
        reset    = 1'b1;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("rb_late_wb_valid", 32'(wb_valid), 32'h0);
        check("rb_late_req", 32'(dmem_req), 32'h0);
        check("rb_late_wb_data", wb_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
